// File: rtl/max_pool_unit.sv
// Streaming per-channel max/min pooling: POOL_SIZE accepted beats reduce to one
// output beat, with a one-deep output register under valid/ready backpressure.

module max_pool_lane #(
    parameter int FEATURE_WIDTH = 32
) (
    input  logic [FEATURE_WIDTH-1:0] acc,
    input  logic [FEATURE_WIDTH-1:0] din,
    input  logic                     min_mode,
    output logic [FEATURE_WIDTH-1:0] red
);
    logic take_din;

    // Equal values keep the accumulator, which is the same value anyway.
    always_comb begin
        take_din = min_mode ? ($signed(din) < $signed(acc)) : ($signed(din) > $signed(acc));
        red      = take_din ? din : acc;
    end
endmodule

module max_pool_unit #(
    parameter int FEATURE_WIDTH = 32,
    parameter int NUM_CH        = 4,
    parameter int POOL_SIZE     = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            mode,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_CH*FEATURE_WIDTH-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_CH*FEATURE_WIDTH-1:0] out_data
);
    localparam int CNT_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POOL_SIZE - 1);

    logic [NUM_CH-1:0][FEATURE_WIDTH-1:0] din, red;
    logic [NUM_CH-1:0][FEATURE_WIDTH-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0][FEATURE_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 mode_q, mode_d;
    logic                                 out_valid_q, out_valid_d;
    logic                                 accept, first_beat, last_beat;

    assign din        = in_data;
    assign in_ready   = (!out_valid_q | out_ready) & !clear;
    assign accept     = in_valid & in_ready;
    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == LAST_CNT);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        max_pool_lane #(.FEATURE_WIDTH(FEATURE_WIDTH)) u_lane (
            .acc      (acc_q[g]),
            .din      (din[g]),
            .min_mode (mode_q),
            .red      (red[g])
        );
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            if (first_beat) begin
                acc_d  = din;
                mode_d = mode;
            end else begin
                acc_d = red;
            end
            // A completing window overrides the consume-clear of out_valid above.
            if (last_beat) begin
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = first_beat ? din : red;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_max_pool_unit.sv
// Bench for max_pool_unit (8-bit, 2 channels, pool of 4): directed scenarios
// plus a randomized run scored against a window-list reference model.

module tb_max_pool_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;

    int errors = 0;
    int checks = 0;

    max_pool_unit #(.FEATURE_WIDTH(8), .NUM_CH(2), .POOL_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pk(input int c0, input int c1);
        return {c1[7:0], c0[7:0]};
    endfunction

    // Reference: plain max/min over a list of signed values.
    function automatic int pool(input int v[$], input bit m);
        int r = v[0];
        foreach (v[i]) if (m ? (v[i] < r) : (v[i] > r)) r = v[i];
        return r;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic beat(input int c0, input int c1, input logic m);
        in_valid = 1'b1; in_data = pk(c0, c1); mode = m;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", out_data); end
        @(negedge clk); rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_max();
        out_ready = 1'b1;
        beat(3, -1, 0); beat(-5, -8, 0); beat(7, -3, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_mid_valid got=%b exp=0", out_valid); end
        beat(2, -2, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL max_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== pk(7, -1)) begin errors++; $display("FAIL max_data got=%h exp=%h", out_data, pk(7, -1)); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_drop got=%b exp=0", out_valid); end
    endtask

    task automatic test_min_flip();
        beat(3, 4, 1); beat(-5, 1, 0); beat(7, 9, 0); beat(2, 6, 0);
        checks++; if (out_data !== pk(-5, 1) || out_valid !== 1'b1) begin
            errors++; $display("FAIL min_flip got=%h/%b exp=%h/1", out_data, out_valid, pk(-5, 1)); end
        step();
    endtask

    task automatic test_sign();
        beat(-128, -128, 0); beat(127, -128, 0); beat(0, -128, 0); beat(-1, -128, 0);
        checks++; if (out_data !== pk(127, -128)) begin errors++; $display("FAIL sign_max got=%h exp=%h", out_data, pk(127, -128)); end
        step();
        beat(-128, -128, 1); beat(127, -128, 1); beat(0, -128, 1); beat(-1, -128, 1);
        checks++; if (out_data !== pk(-128, -128)) begin errors++; $display("FAIL sign_min got=%h exp=%h", out_data, pk(-128, -128)); end
        step();
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        out_ready = 1'b0;
        beat(10, -10, 0); beat(20, -20, 0); beat(30, -30, 0); beat(40, -40, 0);
        held = out_data;
        checks++; if (held !== pk(40, -10) || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_result got=%h/%b exp=%h/1", held, out_valid, pk(40, -10)); end
        in_valid = 1'b1; in_data = pk(5, 5); mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, in_ready); end
            @(posedge clk); #1;
            checks++; if (out_data !== held || out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=%h/1", i, out_data, out_valid, held); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        beat(6, 1, 0); beat(2, 9, 0); beat(3, -4, 0);
        checks++; if (out_data !== pk(6, 9) || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_next got=%h/%b exp=%h/1", out_data, out_valid, pk(6, 9)); end
        step();
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        beat(100, 100, 0); beat(110, 110, 0);
        in_valid = 1'b1; in_data = pk(120, 120); clear = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got=%b exp=0", in_ready); end
        step();
        clear = 1'b0; in_valid = 1'b0;
        beat(1, -3, 0); beat(4, -7, 0); beat(2, -1, 0); beat(3, -9, 0);
        checks++; if (out_data !== pk(4, -1) || out_valid !== 1'b1) begin
            errors++; $display("FAIL clear_window got=%h/%b exp=%h/1", out_data, out_valid, pk(4, -1)); end
        out_ready = 1'b0; clear = 1'b1;
        step();
        checks++; if (out_data !== pk(4, -1) || out_valid !== 1'b1) begin
            errors++; $display("FAIL clear_pending got=%h/%b exp=%h/1", out_data, out_valid, pk(4, -1)); end
        clear = 1'b0; out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        beat(50, 50, 0); beat(60, 60, 0); beat(70, 70, 0);
        #1; rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin
            errors++; $display("FAIL rst_mid got=%h/%b exp=0000/0", out_data, out_valid); end
        @(negedge clk); rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
        beat(1, 2, 0); beat(3, -2, 0); beat(-4, 0, 0); beat(2, 1, 0);
        checks++; if (out_data !== pk(3, 2) || out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_mid_window got=%h/%b exp=%h/1", out_data, out_valid, pk(3, 2)); end
        step();
    endtask

    task automatic test_back_to_back();
        int v0[$], v1[$];
        int nouts = 0;
        logic [15:0] e1, e2;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v0.push_back(int'($urandom_range(0, 255)) - 128);
            v1.push_back(int'($urandom_range(0, 255)) - 128);
        end
        e1 = pk(pool(v0[0:3], 0), pool(v1[0:3], 0));
        e2 = pk(pool(v0[4:7], 1), pool(v1[4:7], 1));
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = pk(v0[i], v1[i]); mode = (i >= 4);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat=%0d got=%b exp=1", i, in_ready); end
            @(posedge clk); #1;
            if (out_valid === 1'b1) nouts++;
            if (i == 3) begin
                checks++; if (out_data !== e1 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b_first got=%h/%b exp=%h/1", out_data, out_valid, e1); end
            end
            if (i == 7) begin
                checks++; if (out_data !== e2 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b_second got=%h/%b exp=%h/1", out_data, out_valid, e2); end
            end
        end
        in_valid = 1'b0;
        checks++; if (nouts != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", nouts); end
        step();
    endtask

    task automatic test_random();
        int w0[$], w1[$];
        bit wm, acc, cons, clr, m;
        int d0, d1, got, cyc;
        logic [15:0] snap;
        logic [15:0] exp_q[$];
        got = 0; cyc = 0;
        in_valid = 1'b0; clear = 1'b1; out_ready = 1'b1;
        step();
        clear = 1'b0;
        while (got < 30 && cyc < 4000) begin
            d0 = int'($urandom_range(0, 255)) - 128;
            d1 = int'($urandom_range(0, 255)) - 128;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = pk(d0, d1);
            mode      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 24) == 0);
            #1;
            checks++; if (in_ready !== ((!out_valid || out_ready) && !clear)) begin
                errors++; $display("FAIL rnd_ready cyc=%0d got=%b", cyc, in_ready); end
            acc = in_valid && in_ready; cons = out_valid && out_ready;
            clr = clear; snap = out_data; m = mode;
            @(posedge clk); #1;
            cyc++;
            if (cons) begin
                checks++;
                if (exp_q.size() == 0 || snap !== exp_q[0]) begin
                    errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, snap, exp_q.size() ? exp_q[0] : 16'hxxxx);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (clr) begin
                w0.delete(); w1.delete();
            end else if (acc) begin
                if (w0.size() == 0) wm = m;
                w0.push_back(d0); w1.push_back(d1);
                if (w0.size() == 4) begin
                    exp_q.push_back(pk(pool(w0, wm), pool(w1, wm)));
                    w0.delete(); w1.delete();
                    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rnd_latency cyc=%0d got=%b exp=1", cyc, out_valid); end
                end
            end
        end
        checks++; if (got < 30) begin errors++; $display("FAIL rnd_timeout outputs=%0d exp=30", got); end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_max();
        test_min_flip();
        test_sign();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
